// File: rtl/bd_word_arbiter.sv
// Round-robin arbiter that merges NREQ BD word sources (leaf_code + payload) into one registered encoder input.
// Latency: 1 cycle from input accept to out_v. PROG leaf codes open a pair lock that holds the grant for the second half.
// Backpressure: in_a is combinational, grant & (~out_v | out_a). A stalled output blocks every source.
//
// Ports:
//   clk, reset (async, active-low)
//   in_v/in_code/in_payload/in_a : per-requester word channel, requester i in slice i
//   out_v/out_code/out_payload/out_a : registered output word channel
//   locked            : registered, high while a PROG pair is open
//   err_lock_timeout  : one-cycle pulse when an open pair is abandoned
//   err_pair_mismatch : one-cycle pulse when the second half has a different leaf code
module bd_word_arbiter #(
   parameter int NREQ         = 4,
   parameter int NPAYLOAD     = 24,
   parameter int NCODE        = 6,
   parameter int PROG_LO      = 26,
   parameter int PROG_HI      = 29,
   parameter int LOCK_TIMEOUT = 1024
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NREQ-1:0]          in_v,
   input  logic [NREQ*NCODE-1:0]    in_code,
   input  logic [NREQ*NPAYLOAD-1:0] in_payload,
   output logic [NREQ-1:0]          in_a,
   output logic                     out_v,
   output logic [NCODE-1:0]         out_code,
   output logic [NPAYLOAD-1:0]      out_payload,
   input  logic                     out_a,
   output logic                     locked,
   output logic                     err_lock_timeout,
   output logic                     err_pair_mismatch
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = $clog2(LOCK_TIMEOUT) + 1;

   typedef enum logic {S_IDLE = 1'b0, S_LOCKED = 1'b1} state_t;

   state_t               state_q, state_d;
   logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
   logic [PW-1:0]        lock_idx_q, lock_idx_d;
   logic [NCODE-1:0]     lock_code_q, lock_code_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 out_v_q, out_v_d;
   logic [NCODE-1:0]     out_code_q, out_code_d;
   logic [NPAYLOAD-1:0]  out_payload_q, out_payload_d;
   logic                 locked_q, locked_d;
   logic                 err_to_q, err_to_d;
   logic                 err_mm_q, err_mm_d;

   logic                 can_load;
   logic                 gnt_any;
   logic [PW-1:0]        gnt_idx;
   logic [PW-1:0]        scan_idx;
   logic                 accept;
   logic [NCODE-1:0]     sel_code;
   logic [NPAYLOAD-1:0]  sel_payload;
   logic                 sel_is_prog;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (int'(p) == NREQ - 1) return '0;
      return p + PW'(1);
   endfunction

   assign can_load = ~out_v_q | out_a;

   // Grant selection: a locked pair only listens to its owner; otherwise scan
   // upward from rr_ptr with wrap.
   always_comb begin
      gnt_any  = 1'b0;
      gnt_idx  = '0;
      scan_idx = '0;
      if (state_q == S_LOCKED) begin
         gnt_any = in_v[lock_idx_q];
         gnt_idx = lock_idx_q;
      end else begin
         for (int k = 0; k < NREQ; k++) begin
            scan_idx = PW'((int'(rr_ptr_q) + k) % NREQ);
            if (!gnt_any && in_v[scan_idx]) begin
               gnt_any = 1'b1;
               gnt_idx = scan_idx;
            end
         end
      end
   end

   // Word mux for the granted requester.
   always_comb begin
      sel_code    = '0;
      sel_payload = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt_idx == PW'(i)) begin
            sel_code    = in_code[i*NCODE +: NCODE];
            sel_payload = in_payload[i*NPAYLOAD +: NPAYLOAD];
         end
      end
   end

   assign sel_is_prog = (int'(sel_code) >= PROG_LO) && (int'(sel_code) <= PROG_HI);

   // Gating with reset keeps every ack low while reset is held, even though
   // the arbitration state is already cleared asynchronously.
   assign accept = reset & can_load & gnt_any;

   // Next-state process.
   always_comb begin
      state_d       = state_q;
      rr_ptr_d      = rr_ptr_q;
      lock_idx_d    = lock_idx_q;
      lock_code_d   = lock_code_q;
      cnt_d         = cnt_q;
      out_v_d       = out_v_q;
      out_code_d    = out_code_q;
      out_payload_d = out_payload_q;
      err_to_d      = 1'b0;
      err_mm_d      = 1'b0;

      if (accept) begin
         out_v_d       = 1'b1;
         out_code_d    = sel_code;
         out_payload_d = sel_payload;
      end else if (out_a) begin
         out_v_d = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (sel_is_prog) begin
                  state_d     = S_LOCKED;
                  lock_idx_d  = gnt_idx;
                  lock_code_d = sel_code;
                  cnt_d       = '0;
               end else begin
                  rr_ptr_d = ptr_inc(gnt_idx);
               end
            end
         end
         S_LOCKED: begin
            // A completing second half takes priority over a timeout on the
            // same edge; it is never itself a lock opener.
            if (accept) begin
               state_d  = S_IDLE;
               rr_ptr_d = ptr_inc(lock_idx_q);
               err_mm_d = (sel_code != lock_code_q);
            end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
               state_d  = S_IDLE;
               rr_ptr_d = ptr_inc(lock_idx_q);
               err_to_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      locked_d = (state_d == S_LOCKED);
   end

   // State register process.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         rr_ptr_q      <= '0;
         lock_idx_q    <= '0;
         lock_code_q   <= '0;
         cnt_q         <= '0;
         out_v_q       <= 1'b0;
         out_code_q    <= '0;
         out_payload_q <= '0;
         locked_q      <= 1'b0;
         err_to_q      <= 1'b0;
         err_mm_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         rr_ptr_q      <= rr_ptr_d;
         lock_idx_q    <= lock_idx_d;
         lock_code_q   <= lock_code_d;
         cnt_q         <= cnt_d;
         out_v_q       <= out_v_d;
         out_code_q    <= out_code_d;
         out_payload_q <= out_payload_d;
         locked_q      <= locked_d;
         err_to_q      <= err_to_d;
         err_mm_q      <= err_mm_d;
      end
   end

   // Output process.
   always_comb begin
      in_a = '0;
      if (accept) in_a[gnt_idx] = 1'b1;
   end

   assign out_v             = out_v_q;
   assign out_code          = out_code_q;
   assign out_payload       = out_payload_q;
   assign locked            = locked_q;
   assign err_lock_timeout  = err_to_q;
   assign err_pair_mismatch = err_mm_q;

endmodule

// File: tb/tb_bd_word_arbiter.sv
module tb_bd_word_arbiter;

   localparam int NREQ = 4;
   localparam int NPAYLOAD = 24;
   localparam int NCODE = 6;
   localparam int LOCK_TIMEOUT = 16;

   logic                     clk = 1'b0;
   logic                     reset = 1'b0;
   logic [NREQ-1:0]          in_v = '0;
   logic [NREQ*NCODE-1:0]    in_code = '0;
   logic [NREQ*NPAYLOAD-1:0] in_payload = '0;
   logic [NREQ-1:0]          in_a;
   logic                     out_v;
   logic [NCODE-1:0]         out_code;
   logic [NPAYLOAD-1:0]      out_payload;
   logic                     out_a = 1'b1;
   logic                     locked;
   logic                     err_lock_timeout;
   logic                     err_pair_mismatch;

   bd_word_arbiter #(
      .NREQ(NREQ), .NPAYLOAD(NPAYLOAD), .NCODE(NCODE),
      .PROG_LO(26), .PROG_HI(29), .LOCK_TIMEOUT(LOCK_TIMEOUT)
   ) dut (
      .clk(clk), .reset(reset),
      .in_v(in_v), .in_code(in_code), .in_payload(in_payload), .in_a(in_a),
      .out_v(out_v), .out_code(out_code), .out_payload(out_payload), .out_a(out_a),
      .locked(locked), .err_lock_timeout(err_lock_timeout), .err_pair_mismatch(err_pair_mismatch)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   // ---------------- reference model (spec rules on plain ints) ----------------
   logic [NCODE+NPAYLOAD-1:0] exp_q[$];
   int  edge_n = 0;
   int  m_locked = 0, m_lock_idx = 0, m_lock_code = 0, m_lock_edge = 0, m_rr = 0;
   int  m_out_v = 0, exp_to = 0, exp_mm = 0;
   logic [NREQ-1:0] last_acc = '0;
   int  locked_cycles = 0;

   always @(negedge clk) begin
      int gi;
      int code;
      int j;
      logic [NREQ-1:0] exp_a;
      bit can;
      last_acc = in_a;
      if (!reset) begin
         check("rst_in_a", in_a, 0);
         check("rst_out_v", out_v, 0);
         check("rst_locked", locked, 0);
         check("rst_errs", {err_lock_timeout, err_pair_mismatch}, 0);
         m_locked = 0; m_rr = 0; m_out_v = 0; exp_to = 0; exp_mm = 0;
         exp_q.delete();
      end else begin
         if (locked) locked_cycles++;
         check("out_v", out_v, m_out_v);
         check("locked", locked, m_locked);
         check("err_lock_timeout", err_lock_timeout, exp_to);
         check("err_pair_mismatch", err_pair_mismatch, exp_mm);
         can = (m_out_v == 0) || out_a;
         gi = -1;
         if (m_locked != 0) begin
            if (in_v[m_lock_idx]) gi = m_lock_idx;
         end else begin
            for (int k = 0; k < NREQ; k++) begin
               j = (m_rr + k) % NREQ;
               if (gi < 0 && in_v[j]) gi = j;
            end
         end
         exp_a = '0;
         if (can && gi >= 0) exp_a[gi] = 1'b1;
         check("in_a", in_a, exp_a);
         exp_to = 0; exp_mm = 0;
         if (exp_a != 0) begin
            code = int'(in_code[gi*NCODE +: NCODE]);
            exp_q.push_back({in_code[gi*NCODE +: NCODE], in_payload[gi*NPAYLOAD +: NPAYLOAD]});
            if (m_locked != 0) begin
               m_locked = 0;
               m_rr = (m_lock_idx + 1) % NREQ;
               if (code != m_lock_code) exp_mm = 1;
            end else if (code >= 26 && code <= 29) begin
               m_locked = 1; m_lock_idx = gi; m_lock_code = code; m_lock_edge = edge_n;
            end else begin
               m_rr = (gi + 1) % NREQ;
            end
         end else if (m_locked != 0 && (edge_n - m_lock_edge) == LOCK_TIMEOUT) begin
            m_locked = 0;
            exp_to = 1;
            m_rr = (m_lock_idx + 1) % NREQ;
         end
         if (exp_a != 0) m_out_v = 1;
         else if (out_a) m_out_v = 0;
      end
      edge_n++;
   end

   // ---------------- output monitor ----------------
   always @(negedge clk) begin
      logic [NCODE+NPAYLOAD-1:0] w;
      if (reset && out_v && out_a) begin
         if (exp_q.size() == 0) begin
            check("unexpected_out_word", {out_code, out_payload}, 0);
         end else begin
            w = exp_q.pop_front();
            check("out_word", {out_code, out_payload}, w);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input bit v, input int code, input int pay);
      in_v[i] = v;
      in_code[i*NCODE +: NCODE] = NCODE'(code);
      in_payload[i*NPAYLOAD +: NPAYLOAD] = NPAYLOAD'(pay);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      in_v = '0;
      out_a = 1'b1;
      cyc();
      cyc();
      check("rst_out_code", out_code, 0);
      check("rst_out_payload", out_payload, 0);
      reset = 1'b1;
   endtask

   task automatic wait_acc(input int idx);
      bit got = 0;
      for (int n = 0; n < 20 && !got; n++) begin
         cyc();
         if (last_acc[idx]) got = 1;
      end
      if (!got) check("wait_acc_timeout", 0, 1);
   endtask

   function automatic int pick_code();
      int r = $urandom_range(0, 7);
      case (r)
         0, 1: return 30;
         2: return 3;
         3: return 40;
         default: return 26 + r - 4;
      endcase
   endfunction

   initial begin
      int cnt, at;
      logic [NCODE+NPAYLOAD-1:0] snap;

      // Round-robin with all sources busy on non-PROG words.
      do_reset();
      for (int i = 0; i < NREQ; i++) set_req(i, 1, 30, i);
      repeat (12) cyc();

      // Pair lock: requester 2 sends two halves 5 cycles apart.
      do_reset();
      set_req(0, 1, 30, 'h100); set_req(1, 1, 30, 'h101); set_req(3, 1, 30, 'h103);
      set_req(2, 1, 27, 'h000ABC);
      wait_acc(2);
      locked_cycles = 0;
      set_req(2, 0, 0, 0);
      repeat (4) cyc();
      set_req(2, 1, 27, 'h000DEF);
      wait_acc(2);
      set_req(2, 0, 0, 0);
      check("lock_span_cycles", locked_cycles, 5);
      repeat (3) cyc();

      // Output stall: out_* hold and no acks while out_a is low.
      do_reset();
      out_a = 1'b0;
      set_req(0, 1, 30, 'h111); set_req(1, 1, 30, 'h222);
      wait_acc(0);
      set_req(0, 0, 0, 0);
      snap = {out_code, out_payload};
      for (int n = 0; n < 10; n++) begin
         check("stall_stable", {out_v, out_code, out_payload}, {1'b1, snap});
         check("stall_no_ack", in_a, 0);
         cyc();
      end
      out_a = 1'b1;
      #1;
      check("drain_and_load", {out_v, in_a}, {1'b1, 4'b0010});
      cyc();
      set_req(1, 0, 0, 0);
      repeat (2) cyc();

      // Lock timeout: requester 1 never sends its second half.
      do_reset();
      set_req(1, 1, 26, 'h5A5);
      wait_acc(1);
      set_req(1, 0, 0, 0);
      set_req(2, 1, 30, 'h202); set_req(3, 1, 30, 'h303);
      cnt = 0; at = 0;
      for (int k = 1; k <= 25; k++) begin
         cyc();
         if (err_lock_timeout) begin cnt++; at = k; end
      end
      check("timeout_pulses", cnt, 1);
      check("timeout_offset", at, 16);

      // Pair mismatch: opened with 28, closed with 29.
      do_reset();
      set_req(0, 1, 28, 'h01);
      wait_acc(0);
      set_req(0, 0, 0, 0);
      cyc();
      set_req(0, 1, 29, 'h02);
      wait_acc(0);
      set_req(0, 0, 0, 0);
      cnt = int'(err_pair_mismatch);
      for (int k = 0; k < 3; k++) begin
         cyc();
         cnt += int'(err_pair_mismatch);
      end
      check("mismatch_pulses", cnt, 1);
      check("mismatch_idle", locked, 0);

      // Asynchronous reset while LOCKED with a held output word.
      do_reset();
      out_a = 1'b0;
      set_req(1, 1, 26, 'h777);
      wait_acc(1);
      for (int i = 0; i < NREQ; i++) set_req(i, 1, 30, 'h400 + i);
      check("pre_reset_state", {out_v, locked}, 2'b11);
      out_a = 1'b1;
      #1;
      reset = 1'b0;
      #1;
      check("async_reset", {out_v, locked, in_a}, 0);
      cyc();
      reset = 1'b1;
      #3;
      check("restart_req0", in_a, 4'b0001);
      repeat (3) cyc();

      // Randomized traffic with backpressure.
      do_reset();
      for (int n = 0; n < 2000; n++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (last_acc[i] || !in_v[i]) begin
               if ($urandom_range(0, 3) != 0) set_req(i, 1, pick_code(), int'($urandom));
               else set_req(i, 0, 0, 0);
            end
         end
         out_a = ($urandom_range(0, 3) != 0);
         cyc();
      end
      in_v = '0;
      out_a = 1'b1;
      repeat (4) cyc();
      check("queue_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
